blk_rx_frame: RTL and testbench
===============================

// Module: blk_rx_frame
// PURPOSE
//  UART receive side of the loopback path: deserialises bytes from o_uart_tx's far end,
//  packs FRAME_LEN bytes into the rx frame memory (addr 0..FRAME_LEN-1), then pulses
//  o_rx_mem_wdone for 1 cycle so the TX block reads the frame back out.
//  Mid-frame gaps are timeout-protected; the memory is locked while the reader is busy.
// PARAMETERS
//  CLKS_PER_BIT  868   i_clk cycles per UART bit (100 MHz / 115200)
//  FRAME_LEN     10    bytes per frame, 1..1023
//  TIMEOUT_CLKS  20000 max idle cycles between bytes inside a frame
//  SOF_BYTE      8'hA5 start-of-frame marker (used only with RX_SOF_EN)
// PORTS
//  i_clk            in   1   system clock
//  i_reset          in   1   synchronous reset, active-high
//  i_uart_rx        in   1   serial input, async, idle high
//  i_rx_mem_rbusy   in   1   reader is consuming the frame; memory must not be written
//  o_rx_mem_wen     out  1   memory write strobe, 1 cycle per byte
//  o_rx_mem_waddr   out  10  write address
//  o_rx_mem_wdata   out  8   write data
//  o_rx_mem_wdone   out  1   1-cycle pulse: frame complete in memory
//  o_led            out  1   toggles on every completed frame
//  o_probe          out  40  debug bus
// BEHAVIOUR
//  Reset: all outputs 0; FSM=S_IDLE; byte index, timeout counter, error counter = 0.
//  uart_rx: 2-FF synchroniser; start bit re-checked at CLKS_PER_BIT/2; data sampled at
//   bit centres, LSB first; stop sampled at centre. Stop=1 -> rx_dv 1-cycle pulse with
//   rx_byte. Stop=0 -> ferr 1-cycle pulse, no rx_dv. Ready for next start right after stop.
//  FSM:
//   S_IDLE:    rx_dv -> write byte at addr 0, idx=1, -> S_COLLECT (FRAME_LEN=1: -> S_DONE)
//   S_COLLECT: rx_dv -> write at addr idx, idx+1; last byte (idx==FRAME_LEN-1) -> S_DONE.
//              Timeout counter clears on rx_dv, else increments; at TIMEOUT_CLKS-1 ->
//              abort, idx=0, err++, -> S_IDLE. rx_dv in the timeout cycle wins (counted).
//              ferr -> abort as for timeout.
//   S_DONE:    o_rx_mem_wdone=1 for exactly this cycle; o_led toggles; -> S_HOLD.
//   S_HOLD:    stay while i_rx_mem_rbusy=1, or for 1 cycle minimum; then -> S_IDLE.
//              rx_dv here is dropped, err++ (overrun); memory is never written.
//  Write latency: o_rx_mem_wen/waddr/wdata registered, 1 cycle after rx_dv.
//  Err counter: 8 bits, saturates at 255; cleared only by reset.
//  ferr in S_IDLE/S_HOLD: err++, no state change.
//  Reset mid-frame: partial frame discarded, no wdone; memory content undefined.
// CONFIGURATION
//  RX_SOF_EN defined: S_IDLE accepts only rx_byte==SOF_BYTE; SOF is not written; the next
//   FRAME_LEN bytes go to addr 0..FRAME_LEN-1. Non-SOF bytes in S_IDLE are dropped silently.
//   Timeout applies from SOF onward.
//  RX_SOF_EN undefined: any byte in S_IDLE starts a frame (as above).
// STRUCTURE
//  Shared package/header: FSM state encodings (S_IDLE..S_HOLD, 2 bits), default
//   CLKS_PER_BIT, FRAME_LEN, SOF_BYTE, memory address width (10).
//  Sub-module uart_rx (CLKS_PER_BIT): i_Clock, i_Rx_Serial -> o_Rx_DV, o_Rx_Byte, o_Rx_Ferr.
//  Top: frame FSM, timeout counter, err counter, probe assembly.
//  o_probe: [7:0] rx_byte, [8] rx_dv, [9] ferr, [11:10] state, [21:12] waddr,
//   [22] wen, [23] wdone, [24] rbusy, [32:25] err count, [39:33] 0.
// TESTING (CLKS_PER_BIT=16, FRAME_LEN=10, TIMEOUT_CLKS=400)
//  Send 0x00..0x09 back-to-back -> 10 writes, addr 0..9, data 0x00..0x09; one wdone
//   1 cycle after the last wen; o_led=1; err=0.
//  Send 4 bytes, idle 500 clks, send 10 bytes -> no wdone for the first 4; err=1;
//   second frame lands at addr 0..9 with a single wdone.
//  Hold rbusy=1 after wdone and send 3 bytes -> no wen; err=3; drop rbusy, send 10 ->
//   normal frame.
//  Byte 3 sent with stop bit 0 -> frame aborted, err=1, next 10 bytes form a clean frame.
//  Assert i_reset at byte 5 -> all outputs 0 next cycle; following 10 bytes -> one wdone.
//  RX_SOF_EN: send 0x11, 0xA5, 0x00..0x09 -> 0x11 dropped (err=0); 10 writes of 0x00..0x09
//   at addr 0..9; one wdone.

Source files
------------

// File: rtl/blk_rx_frame_pkg.sv
// +------------------------------------------------------------------+
// | blk_rx_frame_pkg                                                 |
// | Shared encodings and defaults for the UART receive-frame block.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package blk_rx_frame_pkg;

  localparam int          c_clks_per_bit = 868;
  localparam int          c_frame_len    = 10;
  localparam int          c_timeout_clks = 20000;
  localparam logic [7:0]  c_sof_byte     = 8'hA5;
  localparam int          c_addr_w       = 10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2,
    S_HOLD    = 2'd3
  } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/blk_rx_frame_uart_rx.sv
// +------------------------------------------------------------------+
// | blk_rx_frame_uart_rx                                             |
// | 8N1 UART receiver: centre sampling, framing-error pulse.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module blk_rx_frame_uart_rx
  import blk_rx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Ferr
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t          r_state, w_state_next;
  logic               r_meta, r_sync;
  logic [c_cnt_w-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_byte;
  logic               r_dv, r_ferr;
  logic               w_half, w_full;

  assign w_half = (r_clk_cnt == c_cnt_w'(CLKS_PER_BIT / 2 - 1));
  assign w_full = (r_clk_cnt == c_cnt_w'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE:  if (!r_sync) w_state_next = RX_START;
      // a start pulse that is gone by mid-bit was a glitch
      RX_START: if (w_half) w_state_next = r_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bit_idx == 3'd7) w_state_next = RX_STOP;
      RX_STOP:  if (w_full) w_state_next = RX_IDLE;
      default:  w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_meta    <= 1'b1;
      r_sync    <= 1'b1;
      r_state   <= RX_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_byte    <= '0;
      r_dv      <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_meta  <= i_Rx_Serial;
      r_sync  <= r_meta;
      r_state <= w_state_next;
      r_dv    <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
        end
        RX_START: r_clk_cnt <= w_half ? '0 : r_clk_cnt + 1'b1;
        RX_DATA: begin
          if (w_full) begin
            r_clk_cnt         <= '0;
            r_byte[r_bit_idx] <= r_sync;
            r_bit_idx         <= r_bit_idx + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_full) begin
            r_clk_cnt <= '0;
            r_dv      <= r_sync;
            r_ferr    <= ~r_sync;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_clk_cnt <= '0;
      endcase
    end
  end

  assign o_Rx_DV   = r_dv;
  assign o_Rx_Byte = r_byte;
  assign o_Rx_Ferr = r_ferr;

endmodule

`default_nettype wire

// File: rtl/blk_rx_frame.sv
// +------------------------------------------------------------------+
// | blk_rx_frame                                                     |
// | Packs received UART bytes into frame memory, signals completion. |
// | Optional start-of-frame filtering via macro RX_SOF_EN.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module blk_rx_frame
  import blk_rx_frame_pkg::*;
#(
  parameter int         CLKS_PER_BIT = c_clks_per_bit,
  parameter int         FRAME_LEN    = c_frame_len,
  parameter int         TIMEOUT_CLKS = c_timeout_clks,
  parameter logic [7:0] SOF_BYTE     = c_sof_byte
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_uart_rx,
  input  logic                i_rx_mem_rbusy,
  output logic                o_rx_mem_wen,
  output logic [c_addr_w-1:0] o_rx_mem_waddr,
  output logic [7:0]          o_rx_mem_wdata,
  output logic                o_rx_mem_wdone,
  output logic                o_led,
  output logic [39:0]         o_probe
);

  localparam int                  c_tmo_w    = $clog2(TIMEOUT_CLKS);
  localparam logic [c_addr_w-1:0] c_last_idx = c_addr_w'(FRAME_LEN - 1);
  localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT_CLKS - 1);
`ifdef RX_SOF_EN
  localparam logic c_sof_en = 1'b1;
`else
  localparam logic c_sof_en = 1'b0;
`endif

  logic                w_rx_dv, w_rx_ferr;
  logic [7:0]          w_rx_byte;
  frame_state_t        r_state, w_state_next;
  logic [c_addr_w-1:0] r_idx, w_idx_next;
  logic [c_tmo_w-1:0]  r_tmo, w_tmo_next;
  logic [7:0]          r_err;
  logic                w_wen, w_err_inc;
  logic                r_wen, r_wdone, r_led;
  logic [c_addr_w-1:0] r_waddr;
  logic [7:0]          r_wdata;
  logic [39:0]         r_probe;

  blk_rx_frame_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .i_Clock     (i_clk),
    .i_Reset     (i_reset),
    .i_Rx_Serial (i_uart_rx),
    .o_Rx_DV     (w_rx_dv),
    .o_Rx_Byte   (w_rx_byte),
    .o_Rx_Ferr   (w_rx_ferr)
  );

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_tmo_next   = '0;
    w_wen        = 1'b0;
    w_err_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_dv) begin
          if (c_sof_en) begin
            // the marker itself is not stored; data starts at address 0
            if (w_rx_byte == SOF_BYTE) begin
              w_state_next = S_COLLECT;
              w_idx_next   = '0;
            end
          end else begin
            w_wen = 1'b1;
            if (FRAME_LEN == 1) begin
              w_state_next = S_DONE;
            end else begin
              w_state_next = S_COLLECT;
              w_idx_next   = c_addr_w'(1);
            end
          end
        end else if (w_rx_ferr) begin
          w_err_inc = 1'b1;
        end
      end
      S_COLLECT: begin
        if (w_rx_dv) begin
          w_wen = 1'b1;
          if (r_idx == c_last_idx) begin
            w_state_next = S_DONE;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else if (w_rx_ferr || r_tmo == c_tmo_last) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
          w_err_inc    = 1'b1;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_HOLD;
        w_err_inc    = w_rx_dv | w_rx_ferr;
      end
      S_HOLD: begin
        // bytes arriving while the reader owns the memory are overruns
        if (!i_rx_mem_rbusy) w_state_next = S_IDLE;
        w_err_inc = w_rx_dv | w_rx_ferr;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_err   <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wdone <= 1'b0;
      r_led   <= 1'b0;
      r_probe <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_tmo   <= w_tmo_next;
      r_wen   <= w_wen;
      if (w_wen) begin
        r_waddr <= r_idx;
        r_wdata <= w_rx_byte;
      end
      r_wdone <= (r_state == S_DONE);
      if (r_state == S_DONE) r_led <= ~r_led;
      if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 1'b1;
      r_probe <= {7'd0, r_err, i_rx_mem_rbusy, r_wdone, r_wen, r_waddr,
                  r_state, w_rx_ferr, w_rx_dv, w_rx_byte};
    end
  end

  assign o_rx_mem_wen   = r_wen;
  assign o_rx_mem_waddr = r_waddr;
  assign o_rx_mem_wdata = r_wdata;
  assign o_rx_mem_wdone = r_wdone;
  assign o_led          = r_led;
  assign o_probe        = r_probe;

endmodule

`default_nettype wire

// File: tb/tb_blk_rx_frame.sv
// +------------------------------------------------------------------+
// | tb_blk_rx_frame                                                  |
// | Directed bench for blk_rx_frame with a byte-level frame model.   |
// | Build with RX_SOF_EN to exercise start-of-frame filtering.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_blk_rx_frame;

  localparam int         CPB = 16;
  localparam int         FL  = 10;
  localparam int         TMO = 400;
  localparam logic [7:0] SOF = 8'hA5;
`ifdef RX_SOF_EN
  localparam bit SOF_MODE = 1'b1;
`else
  localparam bit SOF_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        rbusy = 1'b0;
  logic        wen, wdone, led;
  logic [9:0]  waddr;
  logic [7:0]  wdata;
  logic [39:0] probe;

  blk_rx_frame #(
    .CLKS_PER_BIT (CPB),
    .FRAME_LEN    (FL),
    .TIMEOUT_CLKS (TMO),
    .SOF_BYTE     (SOF)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_uart_rx      (rx),
    .i_rx_mem_rbusy (rbusy),
    .o_rx_mem_wen   (wen),
    .o_rx_mem_waddr (waddr),
    .o_rx_mem_wdata (wdata),
    .o_rx_mem_wdone (wdone),
    .o_led          (led),
    .o_probe        (probe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // frame model: what the memory port must show, derived byte by byte
  int exp_addr[$];
  int exp_data[$];
  int m_err, m_n, m_wdone_pend;
  bit m_in_frame, m_hold, m_led;
  int wen_cnt, wdone_cnt;

  function automatic void model_reset();
    exp_addr.delete();
    exp_data.delete();
    m_err = 0; m_n = 0; m_wdone_pend = 0;
    m_in_frame = 0; m_hold = 0; m_led = 0;
    wen_cnt = 0; wdone_cnt = 0;
  endfunction

  function automatic void model_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_in_frame = 0;
      m_n = 0;
      model_err();
      return;
    end
    if (m_hold) begin
      model_err();
      return;
    end
    if (!m_in_frame) begin
      m_in_frame = 1;
      m_n = 0;
      if (SOF_MODE) begin
        if (b != SOF) m_in_frame = 0;
        return;
      end
    end
    exp_addr.push_back(m_n);
    exp_data.push_back(int'(b));
    m_n++;
    if (m_n == FL) begin
      m_in_frame = 0;
      m_n = 0;
      m_wdone_pend++;
      m_led = !m_led;
      m_hold = rbusy;
    end
  endfunction

  function automatic void model_gap(input int clks);
    if (m_in_frame && clks >= TMO) begin
      m_in_frame = 0;
      m_n = 0;
      model_err();
    end
  endfunction

  // all stimulus tasks start and end on a falling edge
  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    model_byte(b, stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
    model_gap(n);
  endtask

  task automatic start_frame();
    if (SOF_MODE) send_byte(SOF);
  endtask

  task automatic send_run(input int first, input int n);
    for (int i = 0; i < n; i++) send_byte(8'(first + i));
  endtask

  task automatic set_rbusy(input bit v);
    rbusy = v;
    if (!v) m_hold = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic checkpoint(input string name, input int lit_err, input int lit_led,
                            input int lit_wen, input int lit_wdone);
    check({name, "_pending_writes"}, exp_addr.size(), 0);
    check({name, "_pending_wdone"}, m_wdone_pend, 0);
    check({name, "_err_model"}, int'(probe[32:25]), m_err);
    check({name, "_err"}, int'(probe[32:25]), lit_err);
    check({name, "_led_model"}, int'(led), int'(m_led));
    check({name, "_led"}, int'(led), lit_led);
    check({name, "_wen_count"}, wen_cnt, lit_wen);
    check({name, "_wdone_count"}, wdone_cnt, lit_wdone);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_wen"}, int'(wen), 0);
    check({name, "_waddr"}, int'(waddr), 0);
    check({name, "_wdata"}, int'(wdata), 0);
    check({name, "_wdone"}, int'(wdone), 0);
    check({name, "_led"}, int'(led), 0);
    check({name, "_probe_lo"}, int'(probe[31:0]), 0);
    check({name, "_probe_hi"}, int'(probe[39:32]), 0);
  endtask

  // per-cycle compare of the memory port against the model queue
  bit prev_last_wen = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      prev_last_wen = 1'b0;
    end else begin
      if (wen) begin
        wen_cnt++;
        check("wen_expected", int'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) begin
          check("waddr", int'(waddr), exp_addr.pop_front());
          check("wdata", int'(wdata), exp_data.pop_front());
        end
      end
      if (wdone) begin
        wdone_cnt++;
        check("wdone_after_last_wen", int'(prev_last_wen), 1);
        check("wdone_expected", int'(m_wdone_pend > 0), 1);
        if (m_wdone_pend > 0) m_wdone_pend--;
      end
      check("probe_pad", int'(probe[39:33]), 0);
      prev_last_wen = wen && (waddr == 10'(FL - 1));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // clean back-to-back frame
    start_frame();
    send_run(8'h00, 10);
    idle(40);
    checkpoint("t1", 0, 1, 10, 1);

    // partial frame lost to an inter-byte timeout, then a full frame
    do_reset();
    start_frame();
    send_run(8'h20, 4);
    idle(500);
    start_frame();
    send_run(8'h30, 10);
    idle(40);
    checkpoint("t2", 1, 1, 14, 1);

    // reader holds the memory: three overruns, then a normal frame
    do_reset();
    start_frame();
    send_run(8'h50, 9);
    set_rbusy(1'b1);
    send_byte(8'h59);
    idle(40);
    send_run(8'h40, 3);
    idle(40);
    checkpoint("t3a", 3, 1, 10, 1);
    set_rbusy(1'b0);
    idle(5);
    start_frame();
    send_run(8'h60, 10);
    idle(40);
    checkpoint("t3b", 3, 0, 20, 2);

    // framing error on byte 3 aborts the frame
    do_reset();
    start_frame();
    send_run(8'h70, 3);
    send_byte(8'h73, 1'b0);
    start_frame();
    send_run(8'h80, 10);
    idle(40);
    checkpoint("t4", 1, 1, 13, 1);

    // reset after five bytes discards the partial frame
    do_reset();
    start_frame();
    send_run(8'h90, 5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    start_frame();
    send_run(8'hB0, 10);
    idle(40);
    checkpoint("t5", 0, 1, 10, 1);

    if (SOF_MODE) begin
      // non-marker byte in idle is ignored without an error
      do_reset();
      send_byte(8'h11);
      send_byte(SOF);
      send_run(8'h00, 10);
      idle(40);
      checkpoint("t6", 0, 1, 10, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
